// File: rtl/ibuf_vc_pkg.sv
// Shared flit format and state encodings for the per-VC input buffer.
package ibuf_vc_pkg;

  localparam int unsigned DATAW    = 8;
  localparam int unsigned TYPE_MSB = DATAW;
  localparam int unsigned TYPE_LSB = DATAW - 1;

  typedef enum logic [1:0] {
    TYPE_BODY = 2'b00,
    TYPE_HEAD = 2'b01,
    TYPE_TAIL = 2'b10,
    TYPE_HT   = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } vc_state_e;

  function automatic logic is_head(input flit_type_e t);
    return (t == TYPE_HEAD) || (t == TYPE_HT);
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return (t == TYPE_TAIL) || (t == TYPE_HT);
  endfunction

endpackage

// File: rtl/ibuf_vc.sv
// Input-VC flit buffer: circular FIFO plus IDLE/ACTIVE packet FSM that
// requests routing for each packet head and returns one credit per dequeue.
module ibuf_vc
  import ibuf_vc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTRW  = 2
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [DATAW:0]  idata,
  input  logic            ivalid,
  input  logic            deq,
  output logic [DATAW:0]  odata,
  output logic            ovalid,
  output logic            rt_en,
  output logic            active,
  output logic            credit,
  output logic [PTRW:0]   count,
  output logic            ovf,
  output logic            perr
);

  localparam logic [PTRW:0]   CNT_FULL = (PTRW + 1)'(DEPTH);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW + 1)'(1);
  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);

  logic [DATAW:0]  mem [DEPTH];
  vc_state_e       state_q, state_d;
  logic [PTRW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTRW:0]   count_q, count_d;
  logic            credit_q, credit_d;
  logic            ovf_q, ovf_d;
  logic            perr_q, perr_d;

  flit_type_e      head_type;
  logic            fifo_nonempty, fifo_full;
  logic            discard, eff_deq, wr_en;

  always_comb begin
    fifo_nonempty = (count_q != '0);
    fifo_full     = (count_q == CNT_FULL);
    head_type     = flit_type_e'(mem[rptr_q][TYPE_MSB:TYPE_LSB]);

    // A non-head flit at the front while idle is orphaned; drop it ourselves.
    discard = (state_q == ST_IDLE) && fifo_nonempty && !is_head(head_type);
    eff_deq = ((state_q == ST_ACTIVE) && deq && fifo_nonempty) || discard;
    wr_en   = ivalid && (!fifo_full || eff_deq);

    wptr_d   = wr_en   ? wptr_q + PTR_ONE : wptr_q;
    rptr_d   = eff_deq ? rptr_q + PTR_ONE : rptr_q;
    count_d  = count_q;
    if (wr_en && !eff_deq) count_d = count_q + CNT_ONE;
    if (!wr_en && eff_deq) count_d = count_q - CNT_ONE;

    credit_d = eff_deq;
    ovf_d    = ovf_q || (ivalid && fifo_full && !eff_deq);
    perr_d   = perr_q || discard;
  end

  always_comb begin
    state_d = state_q;
    rt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty && is_head(head_type)) begin
          rt_en   = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (eff_deq && is_tail(head_type)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= ST_IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= idata;
  end

  always_comb begin
    odata  = mem[rptr_q];
    ovalid = fifo_nonempty;
    active = (state_q == ST_ACTIVE);
    credit = credit_q;
    count  = count_q;
    ovf    = ovf_q;
    perr   = perr_q;
  end

endmodule

// File: tb/tb_ibuf_vc.sv
// Scenario bench for ibuf_vc: expected flits queued on write, popped on dequeue.
module tb_ibuf_vc;
  import ibuf_vc_pkg::*;

  logic           clk;
  logic           rst_;
  logic [DATAW:0] idata;
  logic           ivalid;
  logic           deq;
  logic [DATAW:0] odata;
  logic           ovalid, rt_en, active, credit, ovf, perr;
  logic [2:0]     count;

  int unsigned    errors;
  int unsigned    checks;
  logic [DATAW:0] exp_q [$];
  logic [DATAW:0] exp_f;

  ibuf_vc #(.DEPTH(4), .PTRW(2)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .deq(deq),
    .odata(odata), .ovalid(ovalid), .rt_en(rt_en), .active(active),
    .credit(credit), .count(count), .ovf(ovf), .perr(perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATAW:0] mk(input flit_type_e t, input logic [DATAW-2:0] p);
    return {t, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [DATAW:0] d, input logic dq);
    ivalid = iv;
    idata  = d;
    deq    = dq;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    ivalid = 1'b0;
    deq = 1'b0;
    idata = '0;
    #2;
    rst_ = 1'b1;
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset();
    rst_ = 1'b0; ivalid = 1'b0; deq = 1'b0; idata = '0;
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b exp=0", ovalid); end
    checks++; if (rt_en !== 1'b0) begin errors++; $display("FAIL reset_rt_en got=%b exp=0", rt_en); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (credit !== 1'b0) begin errors++; $display("FAIL reset_credit got=%b exp=0", credit); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", perr); end
    rst_ = 1'b1;
  endtask

  task automatic test_basic_packet();
    do_reset();
    // cycle 1
    drive(1'b1, mk(TYPE_HEAD, 7'h11), 1'b0); exp_q.push_back(idata);
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL basic_ovalid_c1 got=%b exp=0", ovalid); end
    tick();
    // cycle 2
    drive(1'b1, mk(TYPE_BODY, 7'h22), 1'b0); exp_q.push_back(idata);
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL basic_ovalid_c2 got=%b exp=1", ovalid); end
    checks++; if (rt_en !== 1'b1) begin errors++; $display("FAIL basic_rt_en_c2 got=%b exp=1", rt_en); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL basic_active_c2 got=%b exp=0", active); end
    tick();
    // cycle 3
    drive(1'b1, mk(TYPE_TAIL, 7'h33), 1'b1); exp_q.push_back(idata);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL basic_active_c3 got=%b exp=1", active); end
    checks++; if (rt_en !== 1'b0) begin errors++; $display("FAIL basic_rt_en_c3 got=%b exp=0", rt_en); end
    exp_f = exp_q.pop_front();
    checks++; if (odata !== exp_f) begin errors++; $display("FAIL basic_odata_c3 got=%0h exp=%0h", odata, exp_f); end
    tick();
    for (int i = 4; i <= 5; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (credit !== 1'b1) begin errors++; $display("FAIL basic_credit_c%0d got=%b exp=1", i, credit); end
      checks++; if (rt_en !== 1'b0) begin errors++; $display("FAIL basic_rt_en_c%0d got=%b exp=0", i, rt_en); end
      exp_f = exp_q.pop_front();
      checks++; if (odata !== exp_f) begin errors++; $display("FAIL basic_odata_c%0d got=%0h exp=%0h", i, odata, exp_f); end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    checks++; if (credit !== 1'b1) begin errors++; $display("FAIL basic_credit_c6 got=%b exp=1", credit); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL basic_idle_c6 got=%b exp=0", active); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count_c6 got=%0d exp=0", count); end
    tick();
    checks++; if (credit !== 1'b0) begin errors++; $display("FAIL basic_credit_c7 got=%b exp=0", credit); end
  endtask

  task automatic test_simul_full();
    do_reset();
    drive(1'b1, mk(TYPE_HEAD, 7'h41), 1'b0); exp_q.push_back(idata); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(TYPE_BODY, 7'h42 + 7'(i)), 1'b0); exp_q.push_back(idata); tick();
    end
    drive(1'b1, mk(TYPE_TAIL, 7'h4f), 1'b1);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL simul_count_full got=%0d exp=4", count); end
    exp_f = exp_q.pop_front();
    checks++; if (odata !== exp_f) begin errors++; $display("FAIL simul_odata_head got=%0h exp=%0h", odata, exp_f); end
    exp_q.push_back(idata);
    tick();
    drive(1'b0, '0, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL simul_count_after got=%0d exp=4", count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL simul_ovf got=%b exp=0", ovf); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      exp_f = exp_q.pop_front();
      checks++; if (odata !== exp_f) begin errors++; $display("FAIL simul_drain%0d got=%0h exp=%0h", i, odata, exp_f); end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL simul_idle got=%b exp=0", active); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL simul_empty got=%0d exp=0", count); end
  endtask

  task automatic test_perr();
    do_reset();
    drive(1'b1, mk(TYPE_BODY, 7'h55), 1'b0); exp_q.push_back(idata); tick();
    drive(1'b0, '0, 1'b0);
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL perr_ovalid got=%b exp=1", ovalid); end
    checks++; if (rt_en !== 1'b0) begin errors++; $display("FAIL perr_rt_en got=%b exp=0", rt_en); end
    exp_f = exp_q.pop_front();
    checks++; if (odata !== exp_f) begin errors++; $display("FAIL perr_odata got=%0h exp=%0h", odata, exp_f); end
    tick();
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL perr_flag got=%b exp=1", perr); end
    checks++; if (credit !== 1'b1) begin errors++; $display("FAIL perr_credit got=%b exp=1", credit); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL perr_discarded got=%b exp=0", ovalid); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL perr_active got=%b exp=0", active); end
    tick();
    checks++; if (credit !== 1'b0) begin errors++; $display("FAIL perr_credit_once got=%b exp=0", credit); end
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL perr_sticky got=%b exp=1", perr); end
  endtask

  task automatic test_ht_pair();
    do_reset();
    drive(1'b1, mk(TYPE_HT, 7'h61), 1'b0); exp_q.push_back(idata); tick();
    drive(1'b1, mk(TYPE_HT, 7'h62), 1'b0); exp_q.push_back(idata);
    checks++; if (rt_en !== 1'b1) begin errors++; $display("FAIL ht_rt_en_a got=%b exp=1", rt_en); end
    tick();
    drive(1'b0, '0, 1'b1);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL ht_active_a got=%b exp=1", active); end
    checks++; if (rt_en !== 1'b0) begin errors++; $display("FAIL ht_rt_en_gap got=%b exp=0", rt_en); end
    exp_f = exp_q.pop_front();
    checks++; if (odata !== exp_f) begin errors++; $display("FAIL ht_odata_a got=%0h exp=%0h", odata, exp_f); end
    tick();
    drive(1'b0, '0, 1'b1);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL ht_idle_between got=%b exp=0", active); end
    checks++; if (credit !== 1'b1) begin errors++; $display("FAIL ht_credit_a got=%b exp=1", credit); end
    checks++; if (rt_en !== 1'b1) begin errors++; $display("FAIL ht_rt_en_b got=%b exp=1", rt_en); end
    tick();
    drive(1'b0, '0, 1'b1);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL ht_deq_ignored_idle got=%0d exp=1", count); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL ht_active_b got=%b exp=1", active); end
    exp_f = exp_q.pop_front();
    checks++; if (odata !== exp_f) begin errors++; $display("FAIL ht_odata_b got=%0h exp=%0h", odata, exp_f); end
    tick();
    drive(1'b0, '0, 1'b0);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL ht_idle_end got=%b exp=0", active); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL ht_empty got=%b exp=0", ovalid); end
    checks++; if (credit !== 1'b1) begin errors++; $display("FAIL ht_credit_b got=%b exp=1", credit); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    drive(1'b1, mk(TYPE_HEAD, 7'h71), 1'b0); exp_q.push_back(idata); tick();
    drive(1'b1, mk(TYPE_BODY, 7'h72), 1'b0); exp_q.push_back(idata); tick();
    drive(1'b1, mk(TYPE_BODY, 7'h73), 1'b0); exp_q.push_back(idata); tick();
    drive(1'b1, mk(TYPE_TAIL, 7'h74), 1'b0); exp_q.push_back(idata); tick();
    drive(1'b1, mk(TYPE_HEAD, 7'h7e), 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count_full got=%0d exp=4", count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", ovf); end
    tick();
    drive(1'b0, '0, 1'b0);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count_after got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      exp_f = exp_q.pop_front();
      checks++; if (odata !== exp_f) begin errors++; $display("FAIL ovf_drain%0d got=%0h exp=%0h", i, odata, exp_f); end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL ovf_dropped_absent got=%b exp=0", ovalid); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL ovf_idle got=%b exp=0", active); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, mk(TYPE_HEAD, 7'h01), 1'b0); exp_q.push_back(idata); tick();
    drive(1'b1, mk(TYPE_BODY, 7'h02), 1'b0); exp_q.push_back(idata); tick();
    drive(1'b1, mk(TYPE_BODY, 7'h03), 1'b0); exp_q.push_back(idata); tick();
    drive(1'b1, mk(TYPE_BODY, 7'h04), 1'b1);
    exp_f = exp_q.pop_front();
    checks++; if (odata !== exp_f) begin errors++; $display("FAIL arst_odata got=%0h exp=%0h", odata, exp_f); end
    tick();
    drive(1'b0, '0, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL arst_count_pre got=%0d exp=3", count); end
    checks++; if (credit !== 1'b1) begin errors++; $display("FAIL arst_credit_pre got=%b exp=1", credit); end
    rst_ = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL arst_count got=%0d exp=0", count); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL arst_active got=%b exp=0", active); end
    checks++; if (credit !== 1'b0) begin errors++; $display("FAIL arst_credit got=%b exp=0", credit); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL arst_ovalid got=%b exp=0", ovalid); end
    #1;
    rst_ = 1'b1;
    exp_q.delete();
    tick();
    checks++; if (credit !== 1'b0) begin errors++; $display("FAIL arst_no_credit got=%b exp=0", credit); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL arst_still_empty got=%b exp=0", ovalid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_packet();
    test_simul_full();
    test_perr();
    test_ht_pair();
    test_overflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibuf_vc.md
IBUF_VC -- requirements
Module: ibuf_vc

Interface
REQ-001 Parameter DEPTH, default 4, flit entries held; power of two, 2..16.
REQ-002 Parameter PTRW, default 2, log2(DEPTH) pointer width.
REQ-003 clk  input  1  single clock; all state on posedge.
REQ-004 rst_  input  1  reset, asynchronous, active-low.
REQ-005 idata  input  `DATAW+1  incoming flit from link.
REQ-006 ivalid  input  1  write strobe for idata.
REQ-007 deq  input  1  switch grant; dequeues head flit.
REQ-008 odata  output  `DATAW+1  head flit; feeds routing-computation data input.
REQ-009 ovalid  output  1  FIFO non-empty.
REQ-010 rt_en  output  1  one-cycle enable to routing computation for a new packet head.
REQ-011 active  output  1  route held for current packet; switch may grant.
REQ-012 credit  output  1  one-cycle credit return to upstream.
REQ-013 count  output  PTRW+1  occupancy 0..DEPTH.
REQ-014 ovf  output  1  sticky overflow error.
REQ-015 perr  output  1  sticky protocol error.

Function
REQ-016 Flit type = idata[`TYPE_MSB:`TYPE_LSB]: `TYPE_HEAD, `TYPE_BODY, `TYPE_TAIL, `TYPE_HT (single-flit packet).
REQ-017 Circular FIFO; wptr/rptr PTRW bits, wrap DEPTH-1 -> 0; count tracks occupancy separately.
REQ-018 odata = mem[rptr] combinationally; flit written at edge N is visible (ovalid=1) from cycle after edge N.
REQ-019 Write accepted when ivalid & (count<DEPTH | effective dequeue same cycle).
REQ-020 ivalid & full & no effective dequeue: flit dropped, ovf set, FIFO unchanged.
REQ-021 FSM states IDLE, ACTIVE; active=1 exactly in ACTIVE.
REQ-022 IDLE & ovalid & head type HEAD/HT: rt_en=1 (combinational) that cycle; next state ACTIVE.
REQ-023 IDLE & ovalid & head type BODY/TAIL: perr set, flit auto-dequeued (effective dequeue), stay IDLE, rt_en=0.
REQ-024 Effective dequeue = (ACTIVE & deq & ovalid) | REQ-023 discard; deq otherwise ignored.
REQ-025 ACTIVE & effective dequeue of TAIL/HT: next state IDLE; next packet head earns rt_en no earlier than following cycle.
REQ-026 ACTIVE & dequeue of HEAD/BODY: stay ACTIVE.
REQ-027 credit registered: 1 in cycle after each effective dequeue; back-to-back dequeues give back-to-back credits.
REQ-028 Simultaneous write and effective dequeue: count unchanged, both pointers advance; legal at empty only if FIFO non-empty before edge (no fall-through bypass).
REQ-029 rt_en never asserted in ACTIVE or when ovalid=0.
REQ-030 ovf, perr clear only by reset.

Reset
REQ-031 rst_=0 asynchronously: state IDLE, wptr=rptr=0, count=0, credit=0, ovf=0, perr=0; hence ovalid=0, rt_en=0, active=0.
REQ-032 Memory contents not reset; odata undefined while ovalid=0.
REQ-033 Reset mid-packet discards all buffered flits; no credits issued for them.

Structure
REQ-034 `DATAW, `TYPE_MSB, `TYPE_LSB, `TYPE_HEAD/BODY/TAIL/HT, `Enable_ belong in shared define.h.
REQ-035 No sub-module; FIFO storage and FSM in one module; one instance per input VC.

Verification
REQ-036 Reset, write HEAD,BODY,TAIL in cycles 1-3 -> ovalid cycle 2, rt_en=1 cycle 2 only, active from cycle 3; deq each cycle -> credit 1 cycle after each, IDLE after TAIL.
REQ-037 DEPTH=4: write 5 flits without deq -> count=4, ovf=1, 5th flit absent from output order.
REQ-038 Full FIFO, ivalid & deq same cycle while ACTIVE -> count stays 4, ovf=0, order preserved.
REQ-039 BODY flit arrives at head in IDLE -> perr=1, flit discarded, credit=1 next cycle, rt_en=0.
REQ-040 Two HT flits queued -> rt_en pulses for each, separated by >=1 cycle of active=1 with deq.
REQ-041 rst_ low mid-packet (count=3) -> count=0, active=0, credit=0 immediately, no edge required.
